// File: rtl/code_stream_classifier.sv
// Streaming character-code classifier: tags each accepted code as valid letter / vowel,
// forwards it through a one-entry output register and keeps saturating statistics.
module code_stream_classifier #(
  parameter int                  W          = 6,
  parameter logic [(1<<W)-1:0]   VALID_MASK = 64'h0000_0000_07FF_FFFE,
  parameter logic [(1<<W)-1:0]   VOWEL_MASK = 64'h0000_0000_0020_8222,
  parameter int                  CNT_W      = 8,
  parameter int                  MAX_RUN    = 4
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic [W-1:0]     in_code,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             drop_invalid,
  input  logic             clear,
  output logic [W-1:0]     out_code,
  output logic             out_isValid,
  output logic             out_isVowel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] vowel_cnt,
  output logic [CNT_W-1:0] cons_cnt,
  output logic [CNT_W-1:0] inv_cnt,
  output logic             run_alarm
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready depends only on out_valid/out_ready, never on in_valid.

  localparam int               RUN_W   = $clog2(MAX_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_RUN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [W-1:0]     r_out_code;
  logic             r_out_is_valid;
  logic             r_out_is_vowel;
  logic             r_out_valid;
  logic [CNT_W-1:0] r_vowel_cnt;
  logic [CNT_W-1:0] r_cons_cnt;
  logic [CNT_W-1:0] r_inv_cnt;
  logic [RUN_W-1:0] r_run_cnt;
  logic             r_run_alarm;

  logic             w_is_valid;
  logic             w_is_vowel;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_forward;
  logic             w_count;
  logic [RUN_W-1:0] w_run_next;

  assign w_is_valid = VALID_MASK[in_code];
  assign w_is_vowel = VOWEL_MASK[in_code] & w_is_valid;
  assign w_in_ready = reset_L & (~r_out_valid | out_ready);
  assign w_accept   = in_valid & w_in_ready;
  assign w_forward  = w_accept & (w_is_valid | ~drop_invalid);
  // clear wins over statistics but never blocks forwarding
  assign w_count    = w_accept & ~clear;

  always_comb begin
    w_run_next = r_run_cnt;
    if (w_is_valid) begin
      w_run_next = '0;
    end else if (r_run_cnt != RUN_MAX) begin
      w_run_next = r_run_cnt + RUN_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_out_valid    <= 1'b0;
      r_out_code     <= '0;
      r_out_is_valid <= 1'b0;
      r_out_is_vowel <= 1'b0;
    end else if (w_forward) begin
      r_out_valid    <= 1'b1;
      r_out_code     <= in_code;
      r_out_is_valid <= w_is_valid;
      r_out_is_vowel <= w_is_vowel;
    end else if (out_ready) begin
      r_out_valid    <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_vowel_cnt <= '0;
      r_cons_cnt  <= '0;
      r_inv_cnt   <= '0;
      r_run_cnt   <= '0;
      r_run_alarm <= 1'b0;
    end else if (clear) begin
      r_vowel_cnt <= '0;
      r_cons_cnt  <= '0;
      r_inv_cnt   <= '0;
      r_run_cnt   <= '0;
      r_run_alarm <= 1'b0;
    end else if (w_count) begin
      if (w_is_vowel) begin
        if (r_vowel_cnt != CNT_MAX) r_vowel_cnt <= r_vowel_cnt + CNT_W'(1);
      end else if (w_is_valid) begin
        if (r_cons_cnt != CNT_MAX) r_cons_cnt <= r_cons_cnt + CNT_W'(1);
      end else begin
        if (r_inv_cnt != CNT_MAX) r_inv_cnt <= r_inv_cnt + CNT_W'(1);
      end
      r_run_cnt <= w_run_next;
      if (w_run_next == RUN_MAX) r_run_alarm <= 1'b1;
    end
  end

  assign in_ready    = w_in_ready;
  assign out_code    = r_out_code;
  assign out_isValid = r_out_is_valid;
  assign out_isVowel = r_out_is_vowel;
  assign out_valid   = r_out_valid;
  assign vowel_cnt   = r_vowel_cnt;
  assign cons_cnt    = r_cons_cnt;
  assign inv_cnt     = r_inv_cnt;
  assign run_alarm   = r_run_alarm;

endmodule

// File: tb/tb_code_stream_classifier.sv
// Bench for code_stream_classifier: directed scenarios plus random traffic against a
// queue-based reference of the output register and integer statistics.
module tb_code_stream_classifier;

  localparam int W       = 6;
  localparam int CNT_W   = 8;
  localparam int MAX_RUN = 4;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic             clock;
  logic             reset_L;
  logic [W-1:0]     in_code;
  logic             in_valid;
  logic             in_ready;
  logic             drop_invalid;
  logic             clear;
  logic [W-1:0]     out_code;
  logic             out_isValid;
  logic             out_isVowel;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] vowel_cnt;
  logic [CNT_W-1:0] cons_cnt;
  logic [CNT_W-1:0] inv_cnt;
  logic             run_alarm;

  code_stream_classifier #(.W(W), .CNT_W(CNT_W), .MAX_RUN(MAX_RUN)) dut (
    .clock(clock), .reset_L(reset_L), .in_code(in_code), .in_valid(in_valid),
    .in_ready(in_ready), .drop_invalid(drop_invalid), .clear(clear),
    .out_code(out_code), .out_isValid(out_isValid), .out_isVowel(out_isVowel),
    .out_valid(out_valid), .out_ready(out_ready), .vowel_cnt(vowel_cnt),
    .cons_cnt(cons_cnt), .inv_cnt(inv_cnt), .run_alarm(run_alarm)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  logic [W+1:0] exp_q[$];   // {vowel, valid, code}
  int m_vowel_cnt, m_cons_cnt, m_inv_cnt, m_run;
  bit m_alarm;
  int n_checks, n_errors;

  function automatic bit is_letter(int c);
    return (c >= 1) && (c <= 26);
  endfunction

  function automatic bit is_vowel_letter(int c);
    return (c == 1) || (c == 5) || (c == 9) || (c == 15) || (c == 21);
  endfunction

  function automatic int sat_inc(int x);
    return (x >= CNT_SAT) ? CNT_SAT : x + 1;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_vowel_cnt = 0; m_cons_cnt = 0; m_inv_cnt = 0; m_run = 0; m_alarm = 0;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [W+1:0] e;
    check_val("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      check_val("out_code", 32'(out_code), 32'(e[W-1:0]));
      check_val("out_isValid", 32'(out_isValid), 32'(e[W]));
      check_val("out_isVowel", 32'(out_isVowel), 32'(e[W+1]));
    end
    check_val("vowel_cnt", 32'(vowel_cnt), 32'(m_vowel_cnt));
    check_val("cons_cnt", 32'(cons_cnt), 32'(m_cons_cnt));
    check_val("inv_cnt", 32'(inv_cnt), 32'(m_inv_cnt));
    check_val("run_alarm", 32'(run_alarm), 32'(m_alarm));
  endtask

  // Drive one cycle of inputs (called right after a falling edge), then check at the next falling edge.
  task automatic step(input bit v, input int c, input bit ordy, input bit drop, input bit clr);
    bit m_rdy, acc, lv, vw;
    in_valid     = v;
    in_code      = W'(c);
    out_ready    = ordy;
    drop_invalid = drop;
    clear        = clr;
    #1;
    m_rdy = (exp_q.size() == 0) || ordy;
    check_val("in_ready", 32'(in_ready), 32'(m_rdy));
    acc = v && m_rdy;
    lv  = is_letter(c);
    vw  = is_vowel_letter(c);
    @(posedge clock);
    if (ordy && exp_q.size() != 0) void'(exp_q.pop_front());
    if (acc && (lv || !drop)) exp_q.push_back({vw, lv, W'(c)});
    if (clr) begin
      m_vowel_cnt = 0; m_cons_cnt = 0; m_inv_cnt = 0; m_run = 0; m_alarm = 0;
    end else if (acc) begin
      if (vw)      m_vowel_cnt = sat_inc(m_vowel_cnt);
      else if (lv) m_cons_cnt  = sat_inc(m_cons_cnt);
      else         m_inv_cnt   = sat_inc(m_inv_cnt);
      if (lv) m_run = 0;
      else if (m_run < MAX_RUN) m_run++;
      if (m_run == MAX_RUN) m_alarm = 1;
    end
    @(negedge clock);
    check_outputs();
  endtask

  task automatic idle_clear();
    step(0, 0, 1, 0, 1);
  endtask

  // ---------------- stimulus ----------------
  int t1_codes[5] = '{1, 5, 2, 0, 63};
  int t3_codes[4] = '{0, 3, 40, 21};
  bit t3_pulse[4] = '{0, 1, 0, 1};

  initial begin
    n_checks = 0; n_errors = 0;
    model_reset();
    reset_L = 1'b0; in_code = '0; in_valid = 1'b0; drop_invalid = 1'b0;
    clear = 1'b0; out_ready = 1'b0;
    #23;
    check_val("rst_out_valid", 32'(out_valid), 0);
    check_val("rst_out_code", 32'(out_code), 0);
    check_val("rst_flags", 32'({out_isValid, out_isVowel}), 0);
    check_val("rst_cnts", 32'({vowel_cnt, cons_cnt, inv_cnt}), 0);
    check_val("rst_alarm", 32'(run_alarm), 0);
    check_val("rst_in_ready", 32'(in_ready), 0);
    @(negedge clock);
    reset_L = 1'b1;

    // 1: basic stream, full throughput
    foreach (t1_codes[i]) step(1, t1_codes[i], 1, 0, 0);
    step(0, 0, 1, 0, 0);
    check_val("t1_vowel", 32'(vowel_cnt), 2);
    check_val("t1_cons", 32'(cons_cnt), 1);
    check_val("t1_inv", 32'(inv_cnt), 2);

    // 2: backpressure with code 9 held
    step(1, 9, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, $urandom_range(0, 63), 0, 0, 0);
      check_val("t2_hold", 32'(out_code), 9);
    end
    step(1, 15, 1, 0, 0);
    check_val("t2_next", 32'(out_code), 15);
    step(0, 0, 1, 0, 0);

    // 3: drop invalid
    idle_clear();
    foreach (t3_codes[i]) begin
      step(1, t3_codes[i], 1, 1, 0);
      check_val("t3_pulse", 32'(out_valid), 32'(t3_pulse[i]));
    end
    check_val("t3_inv", 32'(inv_cnt), 2);
    check_val("t3_vowel", 32'(vowel_cnt), 1);
    check_val("t3_cons", 32'(cons_cnt), 1);

    // 4: run detection
    idle_clear();
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 0, 0);
      check_val("t4_no_alarm", 32'(run_alarm), 0);
    end
    step(1, 2, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 50 + i, 1, 0, 0);
    check_val("t4_alarm", 32'(run_alarm), 1);
    idle_clear();
    check_val("t4_cleared", 32'(run_alarm), 0);

    // 5: saturation, then clear with a simultaneous accept
    for (int i = 0; i < CNT_SAT + 5; i++) step(1, 1, 1, 0, 0);
    check_val("t5_sat", 32'(vowel_cnt), 32'(CNT_SAT));
    step(1, 2, 1, 0, 1);
    check_val("t5_cons_zero", 32'(cons_cnt), 0);
    check_val("t5_fwd", 32'(out_code), 2);

    // 6: async reset while an entry is held under backpressure
    step(1, 9, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    #2;
    reset_L = 1'b0;
    #1;
    model_reset();
    check_val("t6_out_valid", 32'(out_valid), 0);
    check_val("t6_cnts", 32'({vowel_cnt, cons_cnt, inv_cnt}), 0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clock);
      check_val("t6_in_ready", 32'(in_ready), 0);
    end
    reset_L = 1'b1;

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 63), $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
